// File: rtl/systolic_feeder.sv
// Feeds a weight tile and diagonally skewed feature vectors into the systolic array,
// then flushes zeros through the skew so the array drains before done is pulsed.
module systolic_feeder #(
    parameter int width = 8,
    parameter int row   = 3,
    parameter int col   = 3,
    parameter int cnt_w = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [cnt_w-1:0]       num_vec_in,
    input  logic                   w_valid_in,
    output logic                   w_ready_out,
    input  logic [width*col-1:0]   w_data_in,
    input  logic                   f_valid_in,
    output logic                   f_ready_out,
    input  logic [width*row-1:0]   f_data_in,
    output logic                   ctrl_out,
    output logic [width*col-1:0]   weight_out,
    output logic [width*row-1:0]   feature_out,
    output logic                   busy_out,
    output logic                   done_out
);
    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, FLUSH} state_t;

    localparam int bw = $clog2(row + 1);
    localparam int fw = $clog2(row + col);

    state_t           state, state_nx;
    logic [cnt_w-1:0] vec_cnt, vec_cnt_nx;
    logic [bw-1:0]    beat_cnt, beat_cnt_nx;
    logic [fw-1:0]    flush_cnt, flush_cnt_nx;
    logic             done_nx;
    logic             w_fire, f_fire;

    // Readies are gated by reset so nothing is consumed on an aborting edge.
    assign w_ready_out = !rst_in && (state == LOAD_W);
    assign f_ready_out = !rst_in && (state == STREAM);
    assign busy_out    = (state != IDLE);
    assign w_fire      = w_valid_in && w_ready_out;
    assign f_fire      = f_valid_in && f_ready_out;

    always_comb begin
        state_nx     = state;
        vec_cnt_nx   = vec_cnt;
        beat_cnt_nx  = beat_cnt;
        flush_cnt_nx = flush_cnt;
        done_nx      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    if (num_vec_in != '0) begin
                        vec_cnt_nx  = num_vec_in;
                        beat_cnt_nx = '0;
                        state_nx    = LOAD_W;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    if (beat_cnt == bw'(row - 1)) begin
                        beat_cnt_nx = '0;
                        state_nx    = STREAM;
                    end else begin
                        beat_cnt_nx = beat_cnt + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (f_fire) begin
                    if (vec_cnt != '0)
                        vec_cnt_nx = vec_cnt - 1'b1;
                    if (vec_cnt <= cnt_w'(1)) begin
                        flush_cnt_nx = '0;
                        state_nx     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt == fw'(row + col - 2)) begin
                    flush_cnt_nx = '0;
                    done_nx      = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    flush_cnt_nx = flush_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            vec_cnt    <= '0;
            beat_cnt   <= '0;
            flush_cnt  <= '0;
            ctrl_out   <= 1'b0;
            weight_out <= '0;
            done_out   <= 1'b0;
        end else begin
            state      <= state_nx;
            vec_cnt    <= vec_cnt_nx;
            beat_cnt   <= beat_cnt_nx;
            flush_cnt  <= flush_cnt_nx;
            ctrl_out   <= w_fire;
            weight_out <= w_fire ? w_data_in : '0;
            done_out   <= done_nx;
        end
    end

    // Lane i is i+1 stages deep; idle cycles shift in zero bubbles.
    for (genvar i = 0; i < row; i++) begin : g_lane
        logic [width-1:0] sr [0:i];

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int k = 0; k <= i; k++)
                    sr[k] <= '0;
            end else begin
                sr[0] <= f_fire ? f_data_in[i*width +: width] : '0;
                for (int k = 1; k <= i; k++)
                    sr[k] <= sr[k-1];
            end
        end

        assign feature_out[i*width +: width] = sr[i];
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: predicted array-side outputs are queued
// when handshakes complete and compared cycle by cycle against the DUT.
module tb_systolic_feeder;
    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] num_vec_in = '0;
    logic        w_valid_in = 1'b0;
    logic        w_ready_out;
    logic [23:0] w_data_in = '0;
    logic        f_valid_in = 1'b0;
    logic        f_ready_out;
    logic [23:0] f_data_in = '0;
    logic        ctrl_out;
    logic [23:0] weight_out;
    logic [23:0] feature_out;
    logic        busy_out;
    logic        done_out;

    systolic_feeder #(.width(8), .row(3), .col(3), .cnt_w(16)) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .num_vec_in(num_vec_in), .w_valid_in(w_valid_in),
        .w_ready_out(w_ready_out), .w_data_in(w_data_in),
        .f_valid_in(f_valid_in), .f_ready_out(f_ready_out),
        .f_data_in(f_data_in), .ctrl_out(ctrl_out),
        .weight_out(weight_out), .feature_out(feature_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [23:0] val; } went_t;
    typedef struct { int cyc; int lane; logic [7:0] val; } fent_t;

    went_t wq [$];
    fent_t fq [$];
    int    dq [$];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;
    int    m_remain = 0;
    int    beats_seen = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pk(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic        e_ctrl, e_done;
            logic [23:0] e_w, e_f;
            went_t       we;
            e_ctrl = 1'b0;
            e_w    = '0;
            e_f    = '0;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                we     = wq.pop_front();
                e_ctrl = 1'b1;
                e_w    = we.val;
            end
            for (int k = fq.size() - 1; k >= 0; k--) begin
                if (fq[k].cyc == cyc) begin
                    e_f[fq[k].lane*8 +: 8] = fq[k].val;
                    fq.delete(k);
                end
            end
            e_done = (dq.size() > 0 && dq[0] == cyc);
            if (e_done) void'(dq.pop_front());
            compared++;
            if (ctrl_out !== e_ctrl) begin
                mismatched++;
                $display("FAIL ctrl cyc=%0d got %b want %b", cyc, ctrl_out, e_ctrl);
            end
            compared++;
            if (weight_out !== e_w) begin
                mismatched++;
                $display("FAIL weight cyc=%0d got %h want %h", cyc, weight_out, e_w);
            end
            compared++;
            if (feature_out !== e_f) begin
                mismatched++;
                $display("FAIL feature cyc=%0d got %h want %h", cyc, feature_out, e_f);
            end
            compared++;
            if (done_out !== e_done) begin
                mismatched++;
                $display("FAIL done cyc=%0d got %b want %b", cyc, done_out, e_done);
            end
            if (e_done) begin
                compared++;
                if (busy_out !== 1'b0) begin
                    mismatched++;
                    $display("FAIL busy_at_done cyc=%0d got %b want 0", cyc, busy_out);
                end
            end
            if (rst_in) begin
                wq.delete();
                fq.delete();
                dq.delete();
                m_remain = 0;
            end else begin
                if (w_valid_in && w_ready_out) begin
                    wq.push_back('{cyc + 1, w_data_in});
                    beats_seen++;
                end
                if (f_valid_in && f_ready_out) begin
                    for (int l = 0; l < 3; l++)
                        fq.push_back('{cyc + 1 + l, l, f_data_in[l*8 +: 8]});
                    if (m_remain > 0) begin
                        m_remain--;
                        if (m_remain == 0) dq.push_back(cyc + 6);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [23:0] ws [3], input int stall);
        int   b, guard;
        bit   stalled, acc;
        b = 0;
        guard = 0;
        stalled = 1'b0;
        start_in   = 1'b1;
        num_vec_in = 16'(n);
        m_remain   = n;
        if (n == 0) dq.push_back(cyc + 1);
        step();
        start_in   = 1'b0;
        num_vec_in = '0;
        if (n == 0) return;
        beats_seen = 0;
        while (b < 3 && guard < 30) begin
            guard++;
            if (b == stall && !stalled) begin
                stalled = 1'b1;
                w_valid_in = 1'b0;
                step();
                continue;
            end
            w_valid_in = 1'b1;
            w_data_in  = ws[b];
            acc = w_ready_out;
            step();
            if (acc) b++;
        end
        w_data_in = pk(99, 99, 99);
        compared++;
        if (b != 3 || w_ready_out !== 1'b0) begin
            mismatched++;
            $display("FAIL w_ready_after_load got %b beats %0d want 0 after 3", w_ready_out, b);
        end
        compared++;
        if (f_ready_out !== 1'b1) begin
            mismatched++;
            $display("FAIL f_ready_after_load got %b want 1", f_ready_out);
        end
        step();
        w_valid_in = 1'b0;
        w_data_in  = '0;
        compared++;
        if (beats_seen != 3) begin
            mismatched++;
            $display("FAIL beats_consumed got %0d want 3", beats_seen);
        end
    endtask

    task automatic stream(input logic [23:0] vs [4], input int n, input int gap, input bit last);
        int i, guard;
        bit gapped, acc;
        i = 0;
        guard = 0;
        gapped = 1'b0;
        while (i < n && guard < 50) begin
            guard++;
            if (i == gap && !gapped) begin
                gapped = 1'b1;
                f_valid_in = 1'b0;
                step();
                continue;
            end
            f_valid_in = 1'b1;
            f_data_in  = vs[i];
            acc = f_ready_out;
            step();
            if (acc) i++;
        end
        f_valid_in = 1'b0;
        f_data_in  = '0;
        if (last) begin
            compared++;
            if (i != n || f_ready_out !== 1'b0) begin
                mismatched++;
                $display("FAIL f_ready_in_flush got %b sent %0d want 0 after %0d", f_ready_out, i, n);
            end
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && dq.size() != 0; k++) step();
        compared++;
        if (dq.size() != 0) begin
            mismatched++;
            $display("FAIL done_timeout pending %0d want 0", dq.size());
        end
        step();
    endtask

    task automatic check_idle(input string tag);
        compared++;
        if ({ctrl_out, weight_out, feature_out, busy_out, done_out,
             w_ready_out, f_ready_out} !== '0) begin
            mismatched++;
            $display("FAIL %s got ctrl=%b w=%h f=%h busy=%b done=%b wr=%b fr=%b want all 0",
                     tag, ctrl_out, weight_out, feature_out, busy_out, done_out,
                     w_ready_out, f_ready_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        w_valid_in = 1'b1;
        f_valid_in = 1'b1;
        w_data_in = pk(5, 6, 7);
        f_data_in = pk(8, 9, 10);
        num_vec_in = 16'd5;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        step();
        rst_in = 1'b0;
        w_valid_in = 1'b0;
        f_valid_in = 1'b0;
        w_data_in = '0;
        f_data_in = '0;
        num_vec_in = '0;
        check_idle("reset");
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_weight_load_skew_flush();
        logic [23:0] ws [3];
        logic [23:0] vs [4];
        ws = '{pk(1, 2, 3), pk(4, 5, 6), pk(7, 8, 9)};
        vs = '{pk(10, 20, 30), pk(11, 21, 31), '0, '0};
        load(2, ws, -1);
        stream(vs, 2, -1, 1'b1);
        wait_done();
    endtask

    task automatic test_bubble_stall();
        logic [23:0] ws [3];
        logic [23:0] vs [4];
        ws = '{pk(17, 18, 19), pk(33, 34, 35), pk(65, 66, 67)};
        vs = '{pk(1, 2, 3), pk(4, 5, 6), pk(255, 128, 1), '0};
        load(3, ws, 1);
        stream(vs, 3, 1, 1'b1);
        wait_done();
    endtask

    task automatic test_zero_count();
        logic [23:0] ws [3];
        ws = '{'0, '0, '0};
        load(0, ws, -1);
        wait_done();
    endtask

    task automatic test_abort();
        logic [23:0] ws [3];
        logic [23:0] vs [4];
        ws = '{pk(2, 4, 6), pk(8, 10, 12), pk(14, 16, 18)};
        vs = '{pk(100, 101, 102), pk(103, 104, 105), '0, '0};
        load(4, ws, -1);
        stream(vs, 2, -1, 1'b0);
        f_valid_in = 1'b1;
        f_data_in  = pk(7, 7, 7);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        f_valid_in = 1'b0;
        f_data_in  = '0;
        check_idle("abort");
        repeat (10) step();
        ws = '{pk(3, 1, 4), pk(1, 5, 9), pk(2, 6, 5)};
        vs = '{pk(200, 201, 202), '0, '0, '0};
        load(1, ws, -1);
        stream(vs, 1, -1, 1'b1);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_weight_load_skew_flush();
        test_bubble_stall();
        test_zero_count();
        test_abort();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
